// File: rtl/bcd_pkg.sv
// Shared types and digit arithmetic for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // One double-dabble step for a digit: add-3 correction, then shift left with sin as new LSB.
   function automatic logic [BCD_DIGIT_W-1:0] dd_step(input logic [BCD_DIGIT_W-1:0] d,
                                                        input logic                   sin);
      logic [BCD_DIGIT_W-1:0] a;
      a = add3(d) << 1;
      return a | {{(BCD_DIGIT_W-1){1'b0}}, sin};
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One working BCD digit of the double-dabble shifter; cells chain LSB-to-MSB via sin/sout.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic                   clk,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   sin,
   output logic                   sout,
   output logic [BCD_DIGIT_W-1:0] digit
);

   logic [BCD_DIGIT_W-1:0] a3;

   assign a3   = add3(digit);
   assign sout = a3[BCD_DIGIT_W-1];

   always_ff @(posedge clk) begin
      if (clr) begin
         digit <= '0;
      end else if (en) begin
         digit <= {a3[BCD_DIGIT_W-2:0], sin};
      end
   end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter (double dabble, one shift per clock).
// Define BCD_LZB_EN to enable the registered leading-zero blanking mask on 'blank'.
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 15,
   parameter int DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          overflow,
   output logic [DIGITS-1:0]             blank
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [BIN_W-1:0]     shreg;
   logic                 sticky;
   logic                 accept, shift_en, last;
   logic [DIGITS:0]      chain;
   logic [BCD_W-1:0]     work, work_nxt;

   logic                 busy_r, done_r, ovf_r;
   logic [BCD_W-1:0]     bcd_r;

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign shift_en = (state == SHIFT);
   assign last     = shift_en && (cnt == CNT_W'(1));
   assign chain[0] = shreg[BIN_W-1];

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk   (clk),
         .en    (shift_en),
         .clr   (accept),
         .sin   (chain[k]),
         .sout  (chain[k+1]),
         .digit (work[BCD_DIGIT_W*k +: BCD_DIGIT_W])
      );
      // Value the cell will hold after this shift; lets the result register in the same edge.
      assign work_nxt[BCD_DIGIT_W*k +: BCD_DIGIT_W] =
         dd_step(work[BCD_DIGIT_W*k +: BCD_DIGIT_W], chain[k]);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt    <= CNT_W'(BIN_W);
            sticky <= 1'b0;
         end else if (shift_en) begin
            cnt <= cnt - CNT_W'(1);
            if (chain[DIGITS]) sticky <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         shreg <= bin;
      end else if (shift_en) begin
         shreg <= shreg << 1;
      end
   end

   // Output stage: results land on the edge that enters DONE and hold until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         bcd_r  <= '0;
         ovf_r  <= 1'b0;
      end else begin
         busy_r <= (state_nxt == SHIFT);
         done_r <= (state_nxt == DONE);
         if (last) begin
            bcd_r <= work_nxt;
            ovf_r <= sticky | chain[DIGITS];
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign bcd      = bcd_r;
   assign overflow = ovf_r;

`ifdef BCD_LZB_EN
   logic [DIGITS-1:0] blank_nxt, blank_r;
   logic              zero_above;

   always_comb begin
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above   = zero_above && (work_nxt[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
         blank_nxt[k] = zero_above;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_r <= '0;
      end else if (last) begin
         blank_r <= blank_nxt;
      end
   end

   assign blank = blank_r;
`else
   assign blank = '0;
`endif

endmodule
